character_motion: RTL and testbench
===================================

CHARACTER_MOTION -- requirements
Module: character_motion

Interface
REQ-001 Parameter POS_W, 8, width of x/y position in pixels.
REQ-002 Parameter JUMP_W, 6, width of jump velocity counter.
REQ-003 Parameter JUMP_INIT, 6, jump velocity loaded at take-off; SHALL satisfy 0 < JUMP_INIT < 2^JUMP_W.
REQ-004 Parameter FALL_SPEED, 2, pixels descended per tick while falling.
REQ-005 Parameter WALK_SPEED, 1, pixels moved horizontally per tick.
REQ-006 Parameters X_MIN 0, X_MAX 152, Y_MAX 112, horizontal clamp bounds and floor limit.
REQ-007 Parameters X_START 72, Y_START 100, reset position.
REQ-008 clock  in  1  single clock; all state changes on its rising edge.
REQ-009 resetn  in  1  asynchronous, active-low reset.
REQ-010 enable  in  1  frame tick; position and state advance only on cycles where enable=1.
REQ-011 jump  in  1  jump request pulse; may arrive on any cycle.
REQ-012 move_left, move_right  in  1 each  horizontal move requests, level-sensitive.
REQ-013 left_blocked, right_blocked, up_blocked, down_blocked  in  1 each  collision flags.
REQ-014 x_position, y_position  out  POS_W each  registered character position.
REQ-015 state  out  2  motion state: GROUNDED=0, RISING=1, FALLING=2, LANDED=3.
REQ-016 jump_factor  out  JUMP_W  current upward velocity.
REQ-017 airborne  out  1  high when state is RISING or FALLING (combinational from state).

Function
REQ-018 jump_pending SHALL set on any cycle with jump=1 and clear on every enable cycle after being sampled; jump=1 on an enable cycle counts for that tick.
REQ-019 On an enable tick, GROUNDED with jump request and down_blocked=1: state->RISING, jump_factor<=JUMP_INIT, y unchanged.
REQ-020 On an enable tick, GROUNDED with down_blocked=0 (and no take-off): state->FALLING, y unchanged.
REQ-021 GROUNDED otherwise holds; jump_factor stays 0.
REQ-022 On an enable tick, RISING with up_blocked=0: y<=y-jump_factor saturating at 0, jump_factor decrements by 1; when jump_factor reaches 0, state->FALLING.
REQ-023 On an enable tick, RISING with up_blocked=1: y unchanged, jump_factor<=0, state->FALLING.
REQ-024 On an enable tick, FALLING with down_blocked=0: y<=y+FALL_SPEED saturating at Y_MAX; with down_blocked=1: y unchanged, state->LANDED.
REQ-025 On an enable tick, LANDED->GROUNDED unconditionally; jump requests sampled in LANDED, RISING or FALLING SHALL be discarded.
REQ-026 Horizontal, every enable tick in every state: move_right=1, move_left=0, right_blocked=0 -> x<=min(x+WALK_SPEED, X_MAX); move_left=1, move_right=0, left_blocked=0 -> x<=max(x-WALK_SPEED, X_MIN); both or neither -> x unchanged.
REQ-027 All arithmetic SHALL be computed one bit wider than POS_W before clamping; no wrap-around.
REQ-028 With enable=0, all outputs except jump_pending capture SHALL hold.
REQ-029 Illegal/unreachable state encodings SHALL not exist (all 4 used); no x-propagation.

Reset
REQ-030 resetn=0 SHALL asynchronously force x=X_START, y=Y_START, state=GROUNDED, jump_factor=0, jump_pending=0, airborne=0, including mid-jump.
REQ-031 After resetn deasserts, first state change occurs only on the next enable tick.

Verification
REQ-032 Defaults, y=100, down_blocked=1, jump pulse then 7 enable ticks, down_blocked=0 after take-off -> take-off tick y=100, jf=6; after further 6 ticks y=79, jf=0, state FALLING.
REQ-033 FALLING at y=108, down_blocked=0, 3 ticks -> y=110, 112, 112; then down_blocked=1 tick -> LANDED, next tick -> GROUNDED.
REQ-034 RISING, jf=4, up_blocked=1 on tick -> y unchanged, jf=0, FALLING.
REQ-035 x=151, move_right held 3 ticks -> 152,152,152; right_blocked=1 -> no motion; both moves -> no motion.
REQ-036 jump pulse between ticks while GROUNDED -> honoured at next tick; pulse while FALLING -> discarded, no take-off after LANDED.
REQ-037 resetn asserted mid-rise (y=85, jf=3) -> immediate x=72, y=100, GROUNDED, jf=0.

Source files
------------

// File: rtl/character_motion_if.sv
// Control inputs and position/state outputs of the character motion block.
// master drives requests and collision flags; slave (the motion block) drives position and state.
interface character_motion_if #(
  parameter int unsigned POS_W  = 8,
  parameter int unsigned JUMP_W = 6
);
  logic              enable;
  logic              jump;
  logic              move_left;
  logic              move_right;
  logic              left_blocked;
  logic              right_blocked;
  logic              up_blocked;
  logic              down_blocked;
  logic [POS_W-1:0]  x_position;
  logic [POS_W-1:0]  y_position;
  logic [1:0]        state;
  logic [JUMP_W-1:0] jump_factor;
  logic              airborne;

  modport master (
    output enable, jump, move_left, move_right,
    output left_blocked, right_blocked, up_blocked, down_blocked,
    input  x_position, y_position, state, jump_factor, airborne
  );

  modport slave (
    input  enable, jump, move_left, move_right,
    input  left_blocked, right_blocked, up_blocked, down_blocked,
    output x_position, y_position, state, jump_factor, airborne
  );
endinterface

// File: rtl/character_motion.sv
// Platformer character motion: jump/fall FSM plus clamped horizontal walk, advanced on enable ticks.
// Outputs are registered and update on the clock edge of the tick; inputs are sampled every tick, no backpressure.
module character_motion #(
  parameter int unsigned POS_W      = 8,
  parameter int unsigned JUMP_W     = 6,
  parameter int unsigned JUMP_INIT  = 6,
  parameter int unsigned FALL_SPEED = 2,
  parameter int unsigned WALK_SPEED = 1,
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 152,
  parameter int unsigned Y_MAX      = 112,
  parameter int unsigned X_START    = 72,
  parameter int unsigned Y_START    = 100
) (
  input logic              clock,
  input logic              resetn,
  character_motion_if.slave motion
);

  localparam int unsigned W = POS_W + 1;
  localparam logic [W-1:0]      X_MIN_W = W'(X_MIN);
  localparam logic [W-1:0]      X_MAX_W = W'(X_MAX);
  localparam logic [W-1:0]      Y_MAX_W = W'(Y_MAX);
  localparam logic [JUMP_W-1:0] JF_INIT = JUMP_W'(JUMP_INIT);
  localparam logic [JUMP_W-1:0] JF_ONE  = JUMP_W'(1);

  typedef enum logic [1:0] {GROUNDED = 2'd0, RISING = 2'd1, FALLING = 2'd2, LANDED = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
  logic [JUMP_W-1:0] jf_q, jf_d;
  logic              pend_q, pend_d;
  logic              jump_req;
  logic [W-1:0]      x_inc, x_dec, y_up, y_dn;

  always_comb begin
    jump_req = motion.jump | pend_q;
    // All position arithmetic is one bit wider so overflow/underflow is visible before clamping.
    x_inc    = {1'b0, x_q} + W'(WALK_SPEED);
    x_dec    = {1'b0, x_q} - W'(WALK_SPEED);
    y_up     = {1'b0, y_q} - W'(jf_q);
    y_dn     = {1'b0, y_q} + W'(FALL_SPEED);
    pend_d   = motion.enable ? 1'b0 : (pend_q | motion.jump);
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    jf_d     = jf_q;

    if (motion.enable) begin
      if (motion.move_right && !motion.move_left && !motion.right_blocked) begin
        x_d = (x_inc > X_MAX_W) ? X_MAX_W[POS_W-1:0] : x_inc[POS_W-1:0];
      end else if (motion.move_left && !motion.move_right && !motion.left_blocked) begin
        x_d = (x_dec[W-1] || x_dec < X_MIN_W) ? X_MIN_W[POS_W-1:0] : x_dec[POS_W-1:0];
      end

      case (state_q)
        GROUNDED: begin
          jf_d = '0;
          if (jump_req && motion.down_blocked) begin
            state_d = RISING;
            jf_d    = JF_INIT;
          end else if (!motion.down_blocked) begin
            state_d = FALLING;
          end
        end
        RISING: begin
          if (motion.up_blocked) begin
            jf_d    = '0;
            state_d = FALLING;
          end else begin
            y_d  = y_up[W-1] ? '0 : y_up[POS_W-1:0];
            jf_d = (jf_q != '0) ? jf_q - JF_ONE : '0;
            if (jf_q <= JF_ONE) state_d = FALLING;
          end
        end
        FALLING: begin
          if (!motion.down_blocked) y_d = (y_dn > Y_MAX_W) ? Y_MAX_W[POS_W-1:0] : y_dn[POS_W-1:0];
          else                      state_d = LANDED;
        end
        LANDED: state_d = GROUNDED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= GROUNDED;
      x_q     <= POS_W'(X_START);
      y_q     <= POS_W'(Y_START);
      jf_q    <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      jf_q    <= jf_d;
      pend_q  <= pend_d;
    end
  end

  assign motion.x_position  = x_q;
  assign motion.y_position  = y_q;
  assign motion.state       = state_q;
  assign motion.jump_factor = jf_q;
  assign motion.airborne    = (state_q == RISING) || (state_q == FALLING);

endmodule

// File: tb/tb_character_motion.sv
// Directed bench for character_motion: a vector table for a full jump cycle plus hand sequences for corners.
module tb_character_motion;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  character_motion_if #(.POS_W(8), .JUMP_W(6)) bus ();
  character_motion dut (.clock(clock), .resetn(resetn), .motion(bus));

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic en, jmp, ml, mr, lb, rb, ub, db;
    int   x, y, st, jf;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input int x, input int y, input int st, input int jf);
    check({name, ".x"}, 32'(bus.x_position), x);
    check({name, ".y"}, 32'(bus.y_position), y);
    check({name, ".state"}, 32'(bus.state), st);
    check({name, ".jf"}, 32'(bus.jump_factor), jf);
    check({name, ".airborne"}, 32'(bus.airborne), (st == 1 || st == 2) ? 1 : 0);
  endtask

  task automatic drive(input logic en, input logic jmp, input logic ml, input logic mr,
                       input logic lb, input logic rb, input logic ub, input logic db);
    bus.enable = en;  bus.jump = jmp;
    bus.move_left = ml;  bus.move_right = mr;
    bus.left_blocked = lb;  bus.right_blocked = rb;
    bus.up_blocked = ub;  bus.down_blocked = db;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    // en jmp ml mr lb rb ub db  ->  x  y  st  jf
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 72, 100, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 1, 72, 100, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 1, 72, 100, 1, 6};
    tbl[3]  = '{1, 0, 0, 1, 0, 0, 0, 0, 73,  94, 1, 5};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 0, 0, 74,  89, 1, 4};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 0, 74,  89, 1, 4};
    tbl[6]  = '{1, 0, 1, 0, 0, 0, 0, 0, 73,  85, 1, 3};
    tbl[7]  = '{1, 0, 1, 1, 0, 0, 0, 0, 73,  82, 1, 2};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 73,  80, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 73,  79, 2, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 73,  79, 2, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 73,  81, 2, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 1, 73,  81, 3, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 1, 73,  81, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 1, 73,  81, 0, 0};

    drive(0, 0, 0, 0, 0, 0, 0, 1);
    resetn = 1'b0;
    #12;
    chk_all("reset", 72, 100, 0, 0);
    resetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].en, tbl[i].jmp, tbl[i].ml, tbl[i].mr, tbl[i].lb, tbl[i].rb, tbl[i].ub, tbl[i].db);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].st, tbl[i].jf);
    end

    // Fall from reset height onto the floor limit, then land.
    begin
      int exp_y;
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk_all("fall_start", 72, 100, 2, 0);
      exp_y = 100;
      for (int i = 0; i < 7; i++) begin
        exp_y = (exp_y + 2 > 112) ? 112 : exp_y + 2;
        tick();
        chk_all($sformatf("fall%0d", i), 72, exp_y, 2, 0);
      end
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      tick();
      chk_all("landed", 72, 112, 3, 0);
      tick();
      chk_all("grounded", 72, 112, 0, 0);
    end

    // Ceiling hit mid-rise.
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("ub_takeoff", 72, 100, 1, 6);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    chk_all("ub_rise", 72, 89, 1, 4);
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    chk_all("ub_hit", 72, 89, 2, 0);

    // Asynchronous reset mid-rise with a jump pending.
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 1);
    tick();
    tick();
    tick();
    chk_all("rst_rise", 76, 85, 1, 3);
    drive(0, 1, 0, 0, 0, 0, 0, 1);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk_all("rst_async", 72, 100, 0, 0);
    #2;
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("rst_hold", 72, 100, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("rst_nopend", 72, 100, 0, 0);

    // Horizontal clamps, blocking and conflicting requests.
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 79; i++) tick();
    check("walk_151", 32'(bus.x_position), 151);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("clamp_right%0d", i), 32'(bus.x_position), 152);
    end
    drive(1, 0, 0, 1, 0, 1, 0, 1);
    tick();
    check("right_blocked", 32'(bus.x_position), 152);
    drive(1, 0, 1, 1, 0, 0, 0, 1);
    tick();
    check("both_moves", 32'(bus.x_position), 152);
    drive(1, 0, 1, 0, 0, 0, 0, 1);
    tick();
    check("walk_left", 32'(bus.x_position), 151);
    drive(1, 0, 1, 0, 1, 0, 0, 1);
    tick();
    check("left_blocked", 32'(bus.x_position), 151);
    drive(1, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 151; i++) tick();
    check("walk_0", 32'(bus.x_position), 0);
    tick();
    check("clamp_left", 32'(bus.x_position), 0);
    check("clamp_state", 32'(bus.state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
